// File: rtl/video_timgen_prog.sv
// ----------------------------------------------------------------------------
// video_timgen_prog
//
// Parametrised raster timing generator, advanced by a pixel clock enable.
// Produces horizontal/vertical position counters, sync pulses of selectable
// polarity, a data-enable aligned with the counters, line/frame start
// strobes, a completed-frame counter and a raster-line interrupt.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high, overrides all inputs
//   pix_ce_i       pixel clock enable; one raster step per clk when high
//   irq_en_i       raster interrupt enable
//   irq_line_i     line number that raises the raster interrupt
//   irq_ack_i      clears a pending interrupt
//   hcntr_o        pixel position in the line, 0..H_TOTAL-1
//   vcntr_o        line position in the frame, 0..V_TOTAL-1
//   hsync_o        horizontal sync, asserted level = HSYNC_POL
//   vsync_o        vertical sync, asserted level = VSYNC_POL
//   de_o           data enable, high inside the active window
//   line_start_o   one-clk strobe on the advance into hcntr=0
//   frame_start_o  one-clk strobe on the advance into (0,0)
//   frame_cntr_o   completed frames, wraps modulo 2^FRAME_W
//   irq_o          raster interrupt level
//
// Interrupt handshake: irq_o rises on the advance into (H_ACTIVE, irq_line_i)
// while irq_en_i is high, and stays high until a clk with irq_ack_i=1. A set
// and an ack on the same clk leave irq_o high, so no event is lost; dropping
// irq_en_i only blocks new events and never clears a pending one.
// ----------------------------------------------------------------------------
module video_timgen_prog #(
    parameter int HSIZE     = 10,
    parameter int VSIZE     = 10,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_ce_i,
    input  logic               irq_en_i,
    input  logic [VSIZE-1:0]   irq_line_i,
    input  logic               irq_ack_i,
    output logic [HSIZE-1:0]   hcntr_o,
    output logic [VSIZE-1:0]   vcntr_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic               line_start_o,
    output logic               frame_start_o,
    output logic [FRAME_W-1:0] frame_cntr_o,
    output logic               irq_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > (2 ** HSIZE)) begin : g_hsize_too_small
            $error("video_timgen_prog: HSIZE cannot hold H_TOTAL-1");
        end
        if (V_TOTAL > (2 ** VSIZE)) begin : g_vsize_too_small
            $error("video_timgen_prog: VSIZE cannot hold V_TOTAL-1");
        end
    endgenerate

    localparam logic [HSIZE-1:0] H_LAST     = HSIZE'(H_TOTAL - 1);
    localparam logic [VSIZE-1:0] V_LAST     = VSIZE'(V_TOTAL - 1);
    localparam logic [HSIZE-1:0] HS_FIRST   = HSIZE'(H_ACTIVE + H_FP);
    localparam logic [HSIZE-1:0] HS_LAST    = HSIZE'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VSIZE-1:0] VS_FIRST   = VSIZE'(V_ACTIVE + V_FP);
    localparam logic [VSIZE-1:0] VS_LAST    = VSIZE'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [HSIZE-1:0] H_IRQ_POS  = HSIZE'(H_ACTIVE);
    // One bit wider so the active-window compare also works when the active
    // width equals the full counter range.
    localparam logic [HSIZE:0]   H_ACT_W    = (HSIZE+1)'(H_ACTIVE);
    localparam logic [VSIZE:0]   V_ACT_W    = (VSIZE+1)'(V_ACTIVE);
    localparam logic             HS_ON      = (HSYNC_POL != 0);
    localparam logic             VS_ON      = (VSYNC_POL != 0);

    logic [HSIZE-1:0]   h_q, h_d;
    logic [VSIZE-1:0]   v_q, v_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_cntr_q, frame_cntr_d;
    logic               irq_q, irq_d;
    // Set once the raster has advanced since reset; the very first arrival
    // at (0,0) is the start of a frame, not the completion of one.
    logic               started_q, started_d;
    logic               irq_set;

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cntr_d  = frame_cntr_q;
        started_d     = started_q | pix_ce_i;
        irq_set       = 1'b0;

        if (pix_ce_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + VSIZE'(1);
            end else begin
                h_d = h_q + HSIZE'(1);
            end

            // Syncs and de decode the next position so they land in the same
            // register stage as the counters they describe.
            hsync_d = (h_d >= HS_FIRST && h_d <= HS_LAST) ? HS_ON : ~HS_ON;
            vsync_d = (v_d >= VS_FIRST && v_d <= VS_LAST) ? VS_ON : ~VS_ON;
            de_d    = ({1'b0, h_d} < H_ACT_W) && ({1'b0, v_d} < V_ACT_W);

            line_start_d  = (h_d == '0);
            frame_start_d = (h_d == '0) && (v_d == '0);
            if (frame_start_d && started_q) begin
                frame_cntr_d = frame_cntr_q + FRAME_W'(1);
            end

            // v_d never exceeds V_TOTAL-1, so an out-of-range line never matches.
            irq_set = irq_en_i && (h_d == H_IRQ_POS) && (v_d == irq_line_i);
        end

        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_ack_i) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cntr_q  <= '0;
            irq_q         <= 1'b0;
            started_q     <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cntr_q  <= frame_cntr_d;
            irq_q         <= irq_d;
            started_q     <= started_d;
        end
    end

    assign hcntr_o       = h_q;
    assign vcntr_o       = v_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign frame_cntr_o  = frame_cntr_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_video_timgen_prog.sv
// ----------------------------------------------------------------------------
// tb_video_timgen_prog
//
// Small raster (15x10 total, 8x6 active) so whole frames and the frame counter
// wrap fit in a short run. hsync is built active-high and vsync active-low so
// both polarities are exercised. The reference model counts raster advances
// since reset and derives position, frame number and all decodes from that
// count with plain division/modulo.
// ----------------------------------------------------------------------------
module tb_video_timgen_prog;

    localparam int HW = 4;
    localparam int VW = 4;
    localparam int FW = 3;
    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HP = 1;
    localparam int VP = 0;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_ce_i;
    logic          irq_en_i;
    logic [VW-1:0] irq_line_i;
    logic          irq_ack_i;
    logic [HW-1:0] hcntr_o;
    logic [VW-1:0] vcntr_o;
    logic          hsync_o;
    logic          vsync_o;
    logic          de_o;
    logic          line_start_o;
    logic          frame_start_o;
    logic [FW-1:0] frame_cntr_o;
    logic          irq_o;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int   n_adv = 0;
    int   cur_h = HT - 1;
    int   cur_v = VT - 1;
    logic irq_m = 1'b0;

    video_timgen_prog #(
        .HSIZE(HW), .VSIZE(VW),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HP), .VSYNC_POL(VP), .FRAME_W(FW)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce_i(pix_ce_i),
        .irq_en_i(irq_en_i), .irq_line_i(irq_line_i), .irq_ack_i(irq_ack_i),
        .hcntr_o(hcntr_o), .vcntr_o(vcntr_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .line_start_o(line_start_o), .frame_start_o(frame_start_o),
        .frame_cntr_o(frame_cntr_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s adv=%0d observed=%0h expected=%0h", tag, n_adv, obs, exp);
        end
    endtask

    task automatic check_all(input logic adv);
        int   ef;
        logic ehs, evs, ede, els, efs;
        if (n_adv == 0) begin
            ef  = 0;
            ehs = (HP == 0);
            evs = (VP == 0);
            ede = 1'b0;
        end else begin
            ef  = ((n_adv - 1) / (HT * VT)) % (1 << FW);
            ehs = (cur_h >= HA + HF && cur_h < HA + HF + HS) ? (HP != 0) : (HP == 0);
            evs = (cur_v >= VA + VF && cur_v < VA + VF + VS) ? (VP != 0) : (VP == 0);
            ede = (cur_h < HA) && (cur_v < VA);
        end
        els = adv && (cur_h == 0);
        efs = adv && (cur_h == 0) && (cur_v == 0);
        chk("hcntr", 32'(hcntr_o), 32'(cur_h));
        chk("vcntr", 32'(vcntr_o), 32'(cur_v));
        chk("hsync", 32'(hsync_o), 32'(ehs));
        chk("vsync", 32'(vsync_o), 32'(evs));
        chk("de", 32'(de_o), 32'(ede));
        chk("line_start", 32'(line_start_o), 32'(els));
        chk("frame_start", 32'(frame_start_o), 32'(efs));
        chk("frame_cntr", 32'(frame_cntr_o), 32'(ef));
        chk("irq", 32'(irq_o), 32'(irq_m));
    endtask

    // One clk: drive inputs, advance the model by the rules, then compare.
    task automatic step(input logic r, input logic ce, input logic en,
                        input logic [VW-1:0] line, input logic ack);
        logic adv;
        rst        = r;
        pix_ce_i   = ce;
        irq_en_i   = en;
        irq_line_i = line;
        irq_ack_i  = ack;
        @(posedge clk);
        adv = !r && ce;
        if (r) begin
            n_adv = 0;
            irq_m = 1'b0;
        end else if (adv) begin
            n_adv++;
        end
        if (n_adv == 0) begin
            cur_h = HT - 1;
            cur_v = VT - 1;
        end else begin
            cur_h = (n_adv - 1) % HT;
            cur_v = ((n_adv - 1) / HT) % VT;
        end
        if (!r) begin
            if (adv && en && cur_h == HA && cur_v == int'(line)) irq_m = 1'b1;
            else if (ack) irq_m = 1'b0;
        end
        #1;
        check_all(adv);
    endtask

    // Advance with pix_ce_i=1 until the model sits at (th,tv), bounded.
    task automatic run_to(input string tag, input int th, input int tv, input logic en,
                          input logic [VW-1:0] line, input int bound);
        int k;
        k = 0;
        while (!(cur_h == th && cur_v == tv) && k < bound) begin
            step(1'b0, 1'b1, en, line, 1'b0);
            k++;
        end
        chk(tag, 32'(cur_h == th && cur_v == tv), 32'd1);
    endtask

    initial begin
        rst = 1'b1; pix_ce_i = 1'b0; irq_en_i = 1'b0; irq_line_i = '0; irq_ack_i = 1'b0;

        // reset held, then first advance lands on (0,0)
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("first_h", 32'(hcntr_o), 32'd0);
        chk("first_v", 32'(vcntr_o), 32'd0);
        chk("first_fs", 32'(frame_start_o), 32'd1);
        chk("first_fc", 32'(frame_cntr_o), 32'd0);

        // two full frames continuous
        for (int i = 0; i < 2 * HT * VT; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0);

        // alternate-clk enable: strobes must still be one clk wide
        for (int i = 0; i < 2 * HT * VT; i++) step(1'b0, 1'(i % 2), 1'b0, '0, 1'b0);

        // randomized enable / interrupt traffic, lines beyond V_TOTAL included
        for (int i = 0; i < 700; i++)
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 VW'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0));

        // long run through the frame counter wrap
        for (int i = 0; i < 9 * HT * VT; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0);

        // interrupt: clear, then set and ack on the same clk
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("irq_cleared", 32'(irq_o), 32'd0);
        run_to("reach_7_3", HA - 1, 3, 1'b1, VW'(3), 2 * HT * VT);
        step(1'b0, 1'b1, 1'b1, VW'(3), 1'b1);
        chk("irq_set_wins", 32'(irq_o), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, VW'(3), 1'b0);
        chk("irq_held", 32'(irq_o), 32'd1);
        step(1'b0, 1'b1, 1'b1, VW'(3), 1'b1);
        chk("irq_acked", 32'(irq_o), 32'd0);

        // disabled: a full frame passes line 3 with no interrupt
        for (int i = 0; i < HT * VT + 5; i++) step(1'b0, 1'b1, 1'b0, VW'(3), 1'b0);
        chk("irq_disabled", 32'(irq_o), 32'd0);

        // reset mid-frame with an interrupt pending
        run_to("reach_12_4", 12, 4, 1'b1, VW'(4), 2 * HT * VT);
        chk("irq_before_rst", 32'(irq_o), 32'd1);
        step(1'b1, 1'b1, 1'b1, VW'(4), 1'b0);
        chk("rst_h", 32'(hcntr_o), 32'(HT - 1));
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_fc", 32'(frame_cntr_o), 32'd0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("restart_ls", 32'(line_start_o), 32'd1);
        chk("restart_de", 32'(de_o), 32'd1);
        for (int i = 0; i < HT * VT + 3; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("restart_fc", 32'(frame_cntr_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
